// File: rtl/exec_pkg.sv
// Shared definitions for the execution unit:
// widths, opcode encodings and FSM states.
package exec_pkg;

  localparam int DATA_W = 64;
  localparam int LANE_W = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDL = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_unit_mul.sv
// 32x32 unsigned shift-add multiplier, one
// multiplier bit per clock, 32 iterations.
module seq_mul32
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic              busy_q, busy_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [LANE_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] partial;

  // done flags the final iteration; product is
  // the accumulator after this cycle's step.
  always_comb begin
    partial = mplier_q[0] ? mcand_q : '0;
    product = acc_q + partial;
    done    = busy_q && (cnt_q == 5'd31);
    busy    = busy_q;
  end

  // Load operands on start, then shift the
  // multiplicand up and the multiplier down.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (!busy_q) begin
      if (start) begin
        busy_d   = 1'b1;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{(DATA_W-LANE_W){1'b0}}, a};
        mplier_d = b;
      end
    end else begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31)
        busy_d = 1'b0;
    end
  end

  // Core state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: single-cycle ALU plus a
// sequenced 32-cycle multiply, registered flags.
module exec_unit
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_c_q, flag_c_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [LANE_W-1:0] lane_hi, lane_lo;

  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  logic              wr;
  logic [DATA_W-1:0] wr_res;
  logic              wr_c;

  seq_mul32 u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (opA[LANE_W-1:0]),
    .b       (opB[LANE_W-1:0]),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle ALU on the live operands,
  // captured on the accepting edge.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    lane_hi = opA[DATA_W-1:LANE_W] + opB[DATA_W-1:LANE_W];
    lane_lo = opA[LANE_W-1:0] + opB[LANE_W-1:0];
    unique case (opcode)
      OP_ADD:  {alu_c, alu_res} = {1'b0, opA} + {1'b0, opB};
      OP_SUB:  {alu_c, alu_res} = {1'b0, opA} - {1'b0, opB};
      OP_ADDL: alu_res = {lane_hi, lane_lo};
      OP_AND:  alu_res = opA & opB;
      OP_OR:   alu_res = opA | opB;
      OP_XOR:  alu_res = opA ^ opB;
      OP_MOV:  alu_res = opA;
      default: alu_res = '0;
    endcase
  end

  // Sequencing FSM and result/flag write-back.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    flag_c_d  = flag_c_q;
    mul_start = 1'b0;
    wr        = 1'b0;
    wr_res    = alu_res;
    wr_c      = alu_c;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            wr      = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          wr      = 1'b1;
          wr_res  = mul_prod;
          wr_c    = 1'b0;
          state_d = S_DONE;
        end else if (!mul_busy) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wr) begin
      result_d = wr_res;
      flag_z_d = (wr_res == '0);
      flag_n_d = wr_res[DATA_W-1];
      flag_c_d = wr_c;
    end
  end

  // State, result and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
// Inputs change on negedge; outputs read on negedge.
module tb_exec_unit;
  import exec_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [63:0] opA;
  logic [63:0] opB;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;

  int checks;
  int errors;

  exec_unit dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_op(input logic [2:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clock);
    start  = 1'b1;
    opcode = op;
    opA    = a;
    opB    = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    opA   = 64'hA5A5_5A5A_C3C3_3C3C;
    opB   = 64'h1111_2222_3333_4444;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start  = 1'b0;
    opcode = OP_ADD;
    opA    = '0;
    opB    = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({result, flag_z, flag_n, flag_c,
         busy, done} !== 69'd0) begin
      errors++;
      $display("FAIL reset_state: res=%h z%b n%b c%b busy%b done%b want all 0",
               result, flag_z, flag_n, flag_c,
               busy, done);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        result !== 64'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b res=%h want 0 0 0",
               busy, done, result);
    end
  endtask

  task automatic test_add;
    do_op(OP_ADD, 64'd24, 64'd25);
    @(negedge clock);
    checks++;
    if (result !== 64'd49 || done !== 1'b1 ||
        busy !== 1'b1 || flag_z !== 1'b0 ||
        flag_c !== 1'b0 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL add: res=%0d done%b busy%b z%b c%b n%b want 49 1 1 0 0 0",
               result, done, busy, flag_z,
               flag_c, flag_n);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 ||
        result !== 64'd49) begin
      errors++;
      $display("FAIL add_after: done%b busy%b res=%0d want 0 0 49",
               done, busy, result);
    end
    do_op(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    @(negedge clock);
    checks++;
    if (result !== 64'd0 || flag_z !== 1'b1 ||
        flag_c !== 1'b1 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL add_carry: res=%h z%b c%b n%b want 0 1 1 0",
               result, flag_z, flag_c, flag_n);
    end
    @(negedge clock);
  endtask

  task automatic test_sub;
    do_op(OP_SUB, 64'd0, 64'd1);
    @(negedge clock);
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFF ||
        flag_c !== 1'b1 || flag_n !== 1'b1 ||
        flag_z !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: res=%h c%b n%b z%b want all-ones 1 1 0",
               result, flag_c, flag_n, flag_z);
    end
    @(negedge clock);
    do_op(OP_SUB, 64'd5, 64'd5);
    @(negedge clock);
    checks++;
    if (result !== 64'd0 || flag_z !== 1'b1 ||
        flag_c !== 1'b0 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: res=%h z%b c%b n%b want 0 1 0 0",
               result, flag_z, flag_c, flag_n);
    end
    @(negedge clock);
  endtask

  task automatic test_addl;
    do_op(OP_ADDL, 64'h0000_0001_FFFF_FFFF,
          64'h0000_0001_0000_0001);
    @(negedge clock);
    checks++;
    if (result !== 64'h0000_0002_0000_0000 ||
        flag_c !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL addl: res=%h c%b z%b want 0000000200000000 0 0",
               result, flag_c, flag_z);
    end
    @(negedge clock);
  endtask

  task automatic test_logic;
    do_op(OP_SUB, 64'd0, 64'd2);
    @(negedge clock);
    @(negedge clock);
    do_op(OP_AND, 64'h0000_0000_0000_F0F0,
          64'h0000_0000_0000_FF00);
    @(negedge clock);
    checks++;
    if (result !== 64'hF000 || flag_c !== 1'b0 ||
        flag_n !== 1'b0) begin
      errors++;
      $display("FAIL and: res=%h c%b n%b want f000 0 0",
               result, flag_c, flag_n);
    end
    @(negedge clock);
    do_op(OP_XOR, 64'h1234_5678_9ABC_DEF0,
          64'h1234_5678_9ABC_DEF0);
    @(negedge clock);
    checks++;
    if (result !== 64'd0 || flag_z !== 1'b1) begin
      errors++;
      $display("FAIL xor: res=%h z%b want 0 1",
               result, flag_z);
    end
    @(negedge clock);
    do_op(OP_MOV, 64'h8000_0000_0000_0005,
          64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    checks++;
    if (result !== 64'h8000_0000_0000_0005 ||
        flag_n !== 1'b1 || flag_c !== 1'b0 ||
        flag_z !== 1'b0) begin
      errors++;
      $display("FAIL mov: res=%h n%b c%b z%b want 8000000000000005 1 0 0",
               result, flag_n, flag_c, flag_z);
    end
    @(negedge clock);
  endtask

  task automatic test_mul;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int held_bad;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    held_bad = 0;
    do_op(OP_MUL, 64'hDEAD_BEEF_FFFF_FFFF,
          64'h0123_4567_FFFF_FFFF);
    for (int i = 0; i <= 33; i++) begin
      @(negedge clock);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i < 32 &&
          result !== 64'h8000_0000_0000_0005)
        held_bad++;
      if (i <= 31) begin
        start  = 1'b1;
        opcode = OP_MOV;
        opA    = 64'h0000_0000_0000_0077 + i;
        opB    = 64'd3 * i;
      end else begin
        start = 1'b0;
      end
      if (i == 32) begin
        checks++;
        if (result !== 64'hFFFF_FFFE_0000_0001 ||
            flag_n !== 1'b1 || flag_z !== 1'b0 ||
            flag_c !== 1'b0) begin
          errors++;
          $display("FAIL mul_result: res=%h n%b z%b c%b want fffffffe00000001 1 0 0",
                   result, flag_n, flag_z, flag_c);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != 32) begin
      errors++;
      $display("FAIL mul_done: pulses=%0d at=%0d want 1 at 32",
               done_cnt, done_at);
    end
    checks++;
    if (busy_cnt != 33) begin
      errors++;
      $display("FAIL mul_busy: cycles=%0d want 33",
               busy_cnt);
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL mul_hold: changed_cycles=%0d want 0",
               held_bad);
    end
    checks++;
    if (busy !== 1'b0 ||
        result !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL mul_ignore: busy=%b res=%h want 0 fffffffe00000001",
               busy, result);
    end
  endtask

  task automatic test_reset_mid_mul;
    int bad;
    bad = 0;
    do_op(OP_MUL, 64'd3, 64'd5);
    for (int i = 0; i <= 10; i++)
      @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({result, flag_z, flag_n, flag_c,
         busy, done} !== 69'd0) begin
      errors++;
      $display("FAIL reset_async: res=%h z%b n%b c%b busy%b done%b want all 0",
               result, flag_z, flag_n, flag_c,
               busy, done);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_abort: active_cycles=%0d want 0",
               bad);
    end
    do_op(OP_MOV, 64'h1234, 64'd0);
    @(negedge clock);
    checks++;
    if (result !== 64'h1234 || done !== 1'b1 ||
        flag_z !== 1'b0 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_mov: res=%h done%b z%b n%b want 1234 1 0 0",
               result, done, flag_z, flag_n);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    start  = 1'b1;
    opcode = OP_OR;
    opA    = 64'hF0;
    opB    = 64'h0F;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      checks++;
      if (done !== (j % 2 == 0) ||
          busy !== (j % 2 == 0) ||
          result !== 64'hFF) begin
        errors++;
        $display("FAIL b2b_%0d: done%b busy%b res=%h want %0d %0d ff",
                 j, done, busy, result,
                 (j % 2 == 0), (j % 2 == 0));
      end
    end
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy%b done%b want 0 0",
               busy, done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_addl();
    test_logic();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Sequential execution unit directly downstream of `reg_bank`. Takes the two registered 64-bit operands `outA`/`outB`, runs one operation per `start` (single-cycle logic/arithmetic or a 32-cycle shift-add multiply), and holds the registered result and flags. The result feeds back to `reg_bank` `inA`, and `done` drives its `regwen`.

## Interface
- `DATA_W`, 64: operand/result width. Fixed at 64.
- `LANE_W`, 32: lane width for lane-wise ops and multiplier input width.
- `clock`  in  1  master clock, posedge active
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `opcode`  in  3  operation select, sampled with `start`
- `opA`  in  64  operand A (from `reg_bank.outA`)
- `opB`  in  64  operand B (from `reg_bank.outB`)
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse, result valid; connects to `reg_bank.regwen`
- `result`  out  64  registered result; holds until the next op completes
- `flag_z`  out  1  result == 0
- `flag_n`  out  1  result[63]
- `flag_c`  out  1  carry (ADD) / borrow (SUB); 0 for all other ops

## Operation
- Opcodes:
  - 000 ADD: 64-bit add; `flag_c` = carry-out.
  - 001 SUB: opA−opB mod 2^64; `flag_c`=1 iff opA<opB unsigned.
  - 010 ADDL: independent 32-bit adds on [63:32] and [31:0]; lane carries discarded.
  - 011 AND. 100 OR. 101 XOR.
  - 110 MUL: unsigned opA[31:0]×opB[31:0], 64-bit product.
  - 111 MOV: result = opA.
- Operands and opcode are latched on the edge that accepts `start`. Later changes to `opA`/`opB` have no effect on the op in flight.
- States: IDLE, MUL, DONE.
  - IDLE + `start`, opcode ≠ MUL: write `result`/flags, go to DONE.
  - IDLE + `start`, opcode = MUL: clear accumulator and 5-bit counter, go to MUL.
  - MUL, each edge: if multiplier bit i = 1, acc += multiplicand<<i; counter++.
  - MUL, on the 32nd iteration: write `result`/flags, go to DONE.
  - DONE: `done`=1 for exactly this cycle; next edge goes to IDLE.
- `start` while `busy`=1 is ignored, not queued.
- `flag_z`/`flag_n` are computed from the new result for every op. All flags update only when `result` updates.
- Reset values: `result`=0, all flags 0, `busy`=0, `done`=0, state IDLE, counter 0, accumulator 0.

## Timing
- Let edge k be the edge at which `start` is accepted.
- Single-cycle ops: `result` valid and `done`=1 after edge k. `busy`=1 from edge k to edge k+1. Earliest next accept is edge k+2, so throughput is 1 op per 2 cycles.
- MUL:
  - Iterations happen on edges k+1…k+32.
  - `result` is written and `done`=1 after edge k+32.
  - `busy` is high from edge k to edge k+33.
- `reset` mid-operation: all registers clear immediately, without waiting for a clock edge. The in-flight op is aborted with no `done` pulse. The first accept after release needs `start` high at a posedge with `reset`=0.
- `start` and `reset` together: reset wins.

## Structure
- Package `exec_pkg` holds:
  - opcode localparams: OP_ADD…OP_MOV
  - state encoding: S_IDLE, S_MUL, S_DONE
  - `LANE_W`, `DATA_W`
- Sub-module `seq_mul32`: shift-add core with `clock`, `reset`, `start`, 32-bit a/b, `busy`, `done`, 64-bit `product`. The `exec_unit` FSM sequences it.
- The single-cycle ALU is combinational logic inside `exec_unit`.

## Test plan
- **ADD**: opA=24, opB=25 at accept edge k → `result`=49 after k, `done` high exactly one cycle, `flag_z`=0, `flag_c`=0.
- **SUB**:
  - 0−1 → `result`=0xFFFF_FFFF_FFFF_FFFF, `flag_c`=1, `flag_n`=1.
  - 5−5 → `result`=0, `flag_z`=1, `flag_c`=0.
- **ADDL**: opA=0x0000_0001_FFFF_FFFF, opB=0x0000_0001_0000_0001 → `result`=0x0000_0002_0000_0000, `flag_c`=0.
- **MUL**: opA[31:0]=opB[31:0]=0xFFFF_FFFF → `result`=0xFFFF_FFFE_0000_0001.
  - `done` exactly 32 cycles after edge k.
  - `busy` high for 33 cycles.
  - `start` pulses and operand changes during `busy` have no effect.
- **Reset mid-MUL**: assert `reset` 10 cycles into a MUL, between edges → outputs read 0 before the next edge, no `done`. After release, MOV of 0x1234 → `result`=0x1234.
- **Back-to-back**: hold `start`=1 with OR, 0xF0 | 0x0F → results at edges k and k+2, both 0xFF. Accepts occur only when `busy`=0.
